jtframe_lfbuf_sched: RTL and testbench

//  Schedules line transfers between the line frame buffer and the external PSRAM controller.

---
 rtl/jtframe_lfbuf_sched.sv | 185 ++++++++++++++++++
 tb/tb_jtframe_lfbuf_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_lfbuf_sched.sv
// Line frame buffer scheduler: queues rendered lines for PSRAM writes, issues one
// scan-out read per H blank and owns the double-buffer bank swap.
module jtframe_lfbuf_sched #(
    parameter int VW    = 8,
    parameter int WQ_AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lhbl,
    input  logic          lvbl,
    input  logic [VW-1:0] vrender,
    input  logic          ln_done,
    input  logic [VW-1:0] ln_v,
    output logic          ln_hold,
    output logic          cmd_req,
    output logic          cmd_wr,
    output logic [VW-1:0] cmd_v,
    output logic          cmd_frame,
    input  logic          cmd_ack,
    input  logic          cmd_done,
    output logic          frame,
    output logic          rd_miss,
    output logic          wr_ovf,
    output logic          swap_late,
    output logic [7:0]    miss_cnt
);

    localparam int DEPTH = 2**WQ_AW;

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t            state, state_nx;
    logic              lhbl_r, lvbl_r, done_r;
    logic              hbl_p, vbl_p, done_p;
    logic [VW-1:0]     vr_cap, lnv_cap, rd_vr;
    logic              rd_pend, rd_dirty, swap_pend;
    logic [VW-1:0]     wq_mem [DEPTH];
    logic [WQ_AW-1:0]  wq_wp, wq_rp;
    logic [WQ_AW:0]    wq_cnt;
    logic              full, ack_ok, rd_clr, pop, push_ok, inflight_rd;
    logic              miss_now, ovf_now, late_now, swap_do;
    logic              req_nx, wr_nx, frame_cmd_nx;
    logic [VW-1:0]     v_nx;

    assign full     = (wq_cnt == DEPTH[WQ_AW:0]);
    assign ln_hold  = full;
    assign ack_ok   = (state == REQ) && cmd_ack;
    assign rd_clr   = ack_ok && !cmd_wr;
    assign pop      = ack_ok && cmd_wr;
    assign push_ok  = done_p && (!full || pop);
    assign ovf_now  = done_p && full && !pop;
    // A read counts as in flight from the cycle it is issued until it is acked
    assign inflight_rd = ((state == IDLE) && rd_pend) ||
                         ((state == REQ) && !cmd_wr && !cmd_ack);
    assign miss_now = hbl_p && rd_pend && !(rd_clr && !rd_dirty);
    assign late_now = vbl_p && swap_pend && !swap_do;

    always_comb begin
        state_nx     = state;
        req_nx       = cmd_req;
        wr_nx        = cmd_wr;
        v_nx         = cmd_v;
        frame_cmd_nx = cmd_frame;
        swap_do      = 1'b0;
        case (state)
            IDLE: begin
                if (rd_pend) begin
                    req_nx       = 1'b1;
                    wr_nx        = 1'b0;
                    v_nx         = rd_vr;
                    frame_cmd_nx = frame;
                    state_nx     = REQ;
                end else if (wq_cnt != '0) begin
                    req_nx       = 1'b1;
                    wr_nx        = 1'b1;
                    v_nx         = wq_mem[wq_rp];
                    frame_cmd_nx = ~frame;
                    state_nx     = REQ;
                end else if (swap_pend) begin
                    swap_do = 1'b1;
                end
            end
            REQ: begin
                if (cmd_ack) begin
                    req_nx   = 1'b0;
                    state_nx = cmd_done ? IDLE : BUSY;
                end
            end
            BUSY: begin
                if (cmd_done) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cmd_req   <= 1'b0;
            cmd_wr    <= 1'b0;
            cmd_v     <= '0;
            cmd_frame <= 1'b0;
            frame     <= 1'b0;
        end else begin
            state     <= state_nx;
            cmd_req   <= req_nx;
            cmd_wr    <= wr_nx;
            cmd_v     <= v_nx;
            cmd_frame <= frame_cmd_nx;
            frame     <= frame ^ swap_do;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lhbl_r  <= 1'b0;
            lvbl_r  <= 1'b0;
            done_r  <= 1'b0;
            hbl_p   <= 1'b0;
            vbl_p   <= 1'b0;
            done_p  <= 1'b0;
            vr_cap  <= '0;
            lnv_cap <= '0;
        end else begin
            lhbl_r  <= lhbl;
            lvbl_r  <= lvbl;
            done_r  <= ln_done;
            hbl_p   <= lhbl_r & ~lhbl;
            vbl_p   <= lvbl_r & ~lvbl;
            done_p  <= ~done_r & ln_done;
            if (lhbl_r && !lhbl) vr_cap <= vrender;
            if (!done_r && ln_done) lnv_cap <= ln_v;
        end
    end

    // rd_dirty marks a newer line requested while the issued read is unacked,
    // so the ack must leave rd_pend set for the re-issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            rd_dirty  <= 1'b0;
            rd_vr     <= '0;
            swap_pend <= 1'b0;
            rd_miss   <= 1'b0;
            wr_ovf    <= 1'b0;
            swap_late <= 1'b0;
            miss_cnt  <= '0;
        end else begin
            if (hbl_p) begin
                rd_pend <= 1'b1;
                rd_vr   <= vr_cap;
            end else if (rd_clr) begin
                rd_pend <= rd_dirty;
            end
            rd_dirty  <= (rd_dirty & ~rd_clr) | (hbl_p & inflight_rd);
            swap_pend <= vbl_p | (swap_pend & ~swap_do);
            rd_miss   <= miss_now;
            wr_ovf    <= ovf_now;
            swap_late <= late_now;
            if ((miss_now || late_now) && miss_cnt != 8'hFF)
                miss_cnt <= miss_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wq_wp  <= '0;
            wq_rp  <= '0;
            wq_cnt <= '0;
        end else begin
            if (push_ok) wq_wp <= wq_wp + 1'b1;
            if (pop)     wq_rp <= wq_rp + 1'b1;
            case ({push_ok, pop})
                2'b10:   wq_cnt <= wq_cnt + 1'b1;
                2'b01:   wq_cnt <= wq_cnt - 1'b1;
                default: wq_cnt <= wq_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) wq_mem[wq_wp] <= lnv_cap;
    end

endmodule

// File: tb/tb_jtframe_lfbuf_sched.sv
// Directed bench for jtframe_lfbuf_sched: read/write scheduling, queue limits,
// frame swap, miss counter saturation and asynchronous reset.
module tb_jtframe_lfbuf_sched;

    logic       clk = 1'b0;
    logic       rst_n, lhbl, lvbl, ln_done, cmd_ack, cmd_done;
    logic [7:0] vrender, ln_v;
    logic       ln_hold, cmd_req, cmd_wr, cmd_frame, frame;
    logic       rd_miss, wr_ovf, swap_late;
    logic [7:0] cmd_v, miss_cnt;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    jtframe_lfbuf_sched #(.VW(8), .WQ_AW(2)) dut (
        .clk(clk), .rst_n(rst_n), .lhbl(lhbl), .lvbl(lvbl), .vrender(vrender),
        .ln_done(ln_done), .ln_v(ln_v), .ln_hold(ln_hold), .cmd_req(cmd_req),
        .cmd_wr(cmd_wr), .cmd_v(cmd_v), .cmd_frame(cmd_frame), .cmd_ack(cmd_ack),
        .cmd_done(cmd_done), .frame(frame), .rd_miss(rd_miss), .wr_ovf(wr_ovf),
        .swap_late(swap_late), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [7:0] v);
        ln_v    = v;
        ln_done = 1'b1;
        step();
        ln_done = 1'b0;
        step();
    endtask

    task automatic pulse_ack();
        cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
    endtask

    task automatic pulse_done();
        cmd_done = 1'b1;
        step();
        cmd_done = 1'b0;
    endtask

    // Waits (bounded) for a request, checks it, then acks and completes it
    task automatic serve(input string tag, input logic wr, input logic [7:0] v, input logic fr);
        int unsigned n = 0;
        while (!cmd_req && n < 20) begin
            step();
            n++;
        end
        check({tag, "_req"}, cmd_req, 1'b1);
        check({tag, "_wr"}, cmd_wr, wr);
        check({tag, "_v"}, cmd_v, v);
        check({tag, "_frame"}, cmd_frame, fr);
        pulse_ack();
        pulse_done();
    endtask

    initial begin
        rst_n = 1'b0; lhbl = 1'b1; lvbl = 1'b1; ln_done = 1'b0; ln_v = '0;
        vrender = '0; cmd_ack = 1'b0; cmd_done = 1'b0;
        #1;
        check("rst_req", cmd_req, 1'b0);
        check("rst_frame", frame, 1'b0);
        check("rst_hold", ln_hold, 1'b0);
        check("rst_misscnt", miss_cnt, 8'd0);
        step(); step();
        rst_n = 1'b1;
        step(); step(); step();

        // single read: cmd_req rises on the second edge after the fall is sampled
        lhbl = 1'b0; vrender = 8'h21;
        step();
        lhbl = 1'b1; vrender = 8'h00;
        step();
        check("rd_lat_early", cmd_req, 1'b0);
        step();
        check("rd_req", cmd_req, 1'b1);
        check("rd_wr", cmd_wr, 1'b0);
        check("rd_v", cmd_v, 8'h21);
        check("rd_frame", cmd_frame, 1'b0);
        pulse_ack();
        check("rd_req_drop", cmd_req, 1'b0);
        pulse_done();
        step(); step();
        check("rd_idle", cmd_req, 1'b0);

        // two queued writes drained in order to the back bank
        push_line(8'd10);
        push_line(8'd11);
        check("wq_cnt2", dut.wq_cnt, 3'd2);
        check("wr_v10", cmd_v, 8'd10);
        check("wr_frame", cmd_frame, 1'b1);
        pulse_ack();
        check("wq_cnt1", dut.wq_cnt, 3'd1);
        pulse_done();
        step();
        check("wr_v11", cmd_v, 8'd11);
        check("wr_wr11", cmd_wr, 1'b1);
        cmd_ack = 1'b1; cmd_done = 1'b1;
        step();
        cmd_ack = 1'b0; cmd_done = 1'b0;
        check("wq_cnt0", dut.wq_cnt, 3'd0);
        step();
        check("ackdone_idle", cmd_req, 1'b0);

        // fill queue, overflow, then push+pop while full
        push_line(8'h60); push_line(8'h61); push_line(8'h62); push_line(8'h63);
        check("full_hold", ln_hold, 1'b1);
        check("full_head", cmd_v, 8'h60);
        push_line(8'h65);
        check("ovf_pulse", wr_ovf, 1'b1);
        check("ovf_cnt", dut.wq_cnt, 3'd4);
        step();
        check("ovf_clear", wr_ovf, 1'b0);
        ln_v = 8'h66; ln_done = 1'b1;
        step();
        ln_done = 1'b0; cmd_ack = 1'b1;
        step();
        cmd_ack = 1'b0;
        check("pp_cnt", dut.wq_cnt, 3'd4);
        check("pp_ovf", wr_ovf, 1'b0);
        check("pp_hold", ln_hold, 1'b1);
        pulse_done();
        serve("q61", 1'b1, 8'h61, 1'b1);
        serve("q62", 1'b1, 8'h62, 1'b1);
        serve("q63", 1'b1, 8'h63, 1'b1);
        serve("q66", 1'b1, 8'h66, 1'b1);
        check("drain_hold", ln_hold, 1'b0);

        // read beats write; second hblank before ack re-issues the new line
        ln_v = 8'h40; ln_done = 1'b1; lhbl = 1'b0; vrender = 8'h30;
        step();
        ln_done = 1'b0;
        step();
        step();
        check("prio_wr", cmd_wr, 1'b0);
        check("prio_v", cmd_v, 8'h30);
        lhbl = 1'b1;
        step();
        lhbl = 1'b0; vrender = 8'h31;
        step();
        lhbl = 1'b1;
        step();
        check("rdmiss_pulse", rd_miss, 1'b1);
        check("rdmiss_cnt", miss_cnt, 8'd1);
        check("rdmiss_stable", cmd_v, 8'h30);
        step();
        check("rdmiss_clear", rd_miss, 1'b0);
        serve("rd30", 1'b0, 8'h30, 1'b0);
        serve("rd31", 1'b0, 8'h31, 1'b0);
        serve("wr40", 1'b1, 8'h40, 1'b1);

        // frame swap waits for the queue to drain
        push_line(8'h50);
        push_line(8'h51);
        lvbl = 1'b0; step(); lvbl = 1'b1; step();
        lvbl = 1'b0; step(); lvbl = 1'b1; step();
        check("swap_late", swap_late, 1'b1);
        check("swap_misscnt", miss_cnt, 8'd2);
        check("swap_hold_frame", frame, 1'b0);
        serve("sw50", 1'b1, 8'h50, 1'b1);
        check("swap_mid_frame", frame, 1'b0);
        serve("sw51", 1'b1, 8'h51, 1'b1);
        step();
        check("swap_frame", frame, 1'b1);

        // 300 hblanks with the read never acked: counter saturates
        for (int i = 0; i < 300; i++) begin
            lhbl = 1'b0; vrender = 8'h70; step();
            lhbl = 1'b1; step();
        end
        step(); step();
        check("sat_cnt", miss_cnt, 8'hFF);
        check("sat_req", cmd_req, 1'b1);
        check("sat_frame", cmd_frame, 1'b1);

        // reset while busy
        pulse_ack();
        push_line(8'h01); push_line(8'h02); push_line(8'h03); push_line(8'h04);
        check("pre_rst_hold", ln_hold, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_req", cmd_req, 1'b0);
        check("arst_frame", frame, 1'b0);
        check("arst_hold", ln_hold, 1'b0);
        check("arst_cnt", miss_cnt, 8'd0);
        step();
        rst_n = 1'b1;
        step();
        pulse_done();
        step(); step(); step();
        check("post_rst_req", cmd_req, 1'b0);
        check("post_rst_q", dut.wq_cnt, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
